// File: rtl/cnt_pkg.sv
// Shared types and constants for the mod-N down-counter family.
package cnt_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_XW = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Terminal (highest) count for a given modulus.
  function automatic logic [CNT_W-1:0] max_cnt(input int unsigned modulus);
    return CNT_W'(modulus - 1);
  endfunction

  // Clamp a load value into the legal count range.
  function automatic logic [CNT_W-1:0] sat_load(input logic [CNT_W-1:0] d,
                                                input int unsigned modulus);
    if ({1'b0, d} > CNT_XW'(modulus - 1)) begin
      return max_cnt(modulus);
    end
    return d;
  endfunction

endpackage

// File: rtl/dn_nibble.sv
// 4-bit down-counter slice with load and borrow-chain enable.
module dn_nibble
  import cnt_pkg::*;
#(
  parameter logic [NIB_W-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             LD,
  input  logic [NIB_W-1:0] Din,
  input  logic             BI,
  output logic [NIB_W-1:0] Q,
  output logic             BO
);

  logic [NIB_W-1:0] q_q;
  logic [NIB_W-1:0] q_d;

  // Next value: load wins over decrement; wraps 0 -> F naturally.
  always_comb begin
    q_d = q_q;
    if (LD) begin
      q_d = Din;
    end else if (BI) begin
      q_d = q_q - NIB_W'(1);
    end
  end

  // Slice register with synchronous reset to its share of the top count.
  always_ff @(posedge Clk) begin
    if (MR) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign BO = BI & (q_q == '0);

endmodule

// File: rtl/cnt200_down.sv
// Presettable mod-N down-counter with borrow pulse, auto-reload or one-shot.
module cnt200_down
  import cnt_pkg::*;
#(
  parameter int unsigned MODULUS     = 200,
  parameter int unsigned AUTO_RELOAD = 1
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             CE,
  input  logic             LD,
  input  logic [CNT_W-1:0] D,
  output logic [NIB_W-1:0] QH,
  output logic [NIB_W-1:0] QL,
  output logic             B,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] TOP_VAL = max_cnt(MODULUS);
  localparam bit               RELOAD  = (AUTO_RELOAD != 0);

  state_e           state_q;
  logic             b_q;
  logic             busy_q;

  logic             count_en_c;
  logic             lo_bo_c;
  logic             hi_bo_c;
  logic             expire_c;
  logic             nib_ld_c;
  logic [CNT_W-1:0] nib_din_c;
  logic [NIB_W-1:0] lo_q;
  logic [NIB_W-1:0] hi_q;

  // IDLE counts too: the first CE edge both starts the run and decrements.
  assign count_en_c = CE & ((state_q == ST_IDLE) | (state_q == ST_RUN));

  // Chain borrow out of the high slice means the whole count was zero.
  assign expire_c = hi_bo_c & ~LD;

  // Expiry reuses the load path to force the wrap value (or hold at zero).
  assign nib_ld_c  = LD | expire_c;
  always_comb begin
    nib_din_c = RELOAD ? TOP_VAL : '0;
    if (LD) begin
      nib_din_c = sat_load(D, MODULUS);
    end
  end

  dn_nibble #(
    .RST_VAL (TOP_VAL[NIB_W-1:0])
  ) u_lo (
    .Clk (Clk),
    .MR  (MR),
    .LD  (nib_ld_c),
    .Din (nib_din_c[NIB_W-1:0]),
    .BI  (count_en_c),
    .Q   (lo_q),
    .BO  (lo_bo_c)
  );

  dn_nibble #(
    .RST_VAL (TOP_VAL[CNT_W-1:NIB_W])
  ) u_hi (
    .Clk (Clk),
    .MR  (MR),
    .LD  (nib_ld_c),
    .Din (nib_din_c[CNT_W-1:NIB_W]),
    .BI  (lo_bo_c),
    .Q   (hi_q),
    .BO  (hi_bo_c)
  );

  // Control FSM with registered borrow pulse and busy flag.
  always_ff @(posedge Clk) begin
    if (MR) begin
      state_q <= ST_IDLE;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else if (LD) begin
      state_q <= ST_RUN;
      b_q     <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      b_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (CE) begin
            if (expire_c) begin
              b_q <= 1'b1;
              if (RELOAD) begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
              end
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign QH   = hi_q;
  assign QL   = lo_q;
  assign B    = b_q;
  assign BUSY = busy_q;

endmodule
